// File: rtl/phase_light_controller_pkg.sv
// ============================================================================
// Module   : light_package
// Brief    : Lamp colours and controller state encoding shared by the
//            phase light controller and its testbench.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package light_package;

    typedef enum logic [1:0] {
        COLOR_RED    = 2'd0,
        COLOR_YELLOW = 2'd1,
        COLOR_GREEN  = 2'd2
    } colors;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        CLEAR  = 2'd3
    } tlc_phase_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_phase_arbiter.sv
// ============================================================================
// Module   : rr_phase_arbiter
// Brief    : Combinational phase selector. TLC_ROUND_ROBIN_EN selects
//            round-robin from last+1; otherwise lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_phase_arbiter
    import light_package::*;
#(
    parameter int NUM_PHASES = 5
) (
    input  logic [NUM_PHASES-1:0]         demand,
    input  logic [$clog2(NUM_PHASES)-1:0] last,
    output logic [$clog2(NUM_PHASES)-1:0] grant,
    output logic                          any_req
);

    localparam int c_IDX_W = $clog2(NUM_PHASES);

    assign any_req = |demand;

`ifdef TLC_ROUND_ROBIN_EN
    logic               w_found;
    logic [c_IDX_W-1:0] w_idx;

    // Search starts just after the last-served phase, so it is only regranted
    // once every other phase has been passed over.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        grant   = '0;
        for (int i = 1; i <= NUM_PHASES; i++) begin
            w_idx = c_IDX_W'((int'(last) + i) % NUM_PHASES);
            if (!w_found && demand[w_idx]) begin
                grant   = w_idx;
                w_found = 1'b1;
            end
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^last;

    always_comb begin
        grant = '0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (demand[i]) grant = c_IDX_W'(i);
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/phase_light_controller.sv
// ============================================================================
// Module   : phase_light_controller
// Brief    : N-phase traffic-light controller with gap, max-green, yellow and
//            all-red timing. Define TLC_ROUND_ROBIN_EN for round-robin service.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_light_controller
    import light_package::*;
#(
    parameter int NUM_PHASES    = 5,
    parameter int GAP_CYCLES    = 5,
    parameter int MAX_GREEN     = 10,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PHASES-1:0]         demand,
    output colors                         light [NUM_PHASES],
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic                          phase_valid
);

    localparam int c_IDX_W   = $clog2(NUM_PHASES);
    localparam int c_GREEN_W = $clog2(MAX_GREEN + 1);
    localparam int c_GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int c_TMR_MAX = (YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_GREEN_W-1:0] c_GREEN_LAST  = c_GREEN_W'(MAX_GREEN - 1);
    localparam logic [c_GAP_W-1:0]   c_GAP_LAST    = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]   c_YELLOW_LAST = c_TMR_W'(YELLOW_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]   c_ALLRED_LAST = c_TMR_W'(ALLRED_CYCLES - 1);

    tlc_phase_state_t   r_state,     w_state_nxt;
    logic [c_IDX_W-1:0] r_cur,       w_cur_nxt;
    logic [c_IDX_W-1:0] r_last,      w_last_nxt;
    logic [c_GREEN_W-1:0] r_green_ctr, w_green_nxt;
    logic [c_GAP_W-1:0]   r_gap_ctr,   w_gap_nxt;
    logic [c_TMR_W-1:0]   r_tmr,       w_tmr_nxt;

    logic [c_IDX_W-1:0]    w_grant;
    logic                  w_any_req;
    logic [NUM_PHASES-1:0] w_others;

    rr_phase_arbiter #(
        .NUM_PHASES (NUM_PHASES)
    ) u_arbiter (
        .demand  (demand),
        .last    (r_last),
        .grant   (w_grant),
        .any_req (w_any_req)
    );

    assign w_others = demand & ~(NUM_PHASES'(1) << r_cur);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cur       <= '0;
            r_last      <= c_IDX_W'(NUM_PHASES - 1);
            r_green_ctr <= '0;
            r_gap_ctr   <= '0;
            r_tmr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur       <= w_cur_nxt;
            r_last      <= w_last_nxt;
            r_green_ctr <= w_green_nxt;
            r_gap_ctr   <= w_gap_nxt;
            r_tmr       <= w_tmr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_last_nxt  = r_last;
        w_green_nxt = r_green_ctr;
        w_gap_nxt   = r_gap_ctr;
        w_tmr_nxt   = r_tmr;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_cur_nxt   = w_grant;
                    w_last_nxt  = w_grant;
                    w_green_nxt = '0;
                    w_gap_nxt   = '0;
                    w_state_nxt = GREEN;
                end
            end
            GREEN: begin
                if (r_green_ctr != c_GREEN_LAST) w_green_nxt = r_green_ctr + 1'b1;
                // Returning traffic on the green phase restarts the gap.
                if (demand[r_cur]) w_gap_nxt = '0;
                else               w_gap_nxt = r_gap_ctr + 1'b1;
                if ((!demand[r_cur] && (r_gap_ctr == c_GAP_LAST)) ||
                    ((r_green_ctr == c_GREEN_LAST) && (|w_others))) begin
                    w_state_nxt = YELLOW;
                    w_tmr_nxt   = '0;
                end
            end
            YELLOW: begin
                if (r_tmr == c_YELLOW_LAST) begin
                    w_state_nxt = CLEAR;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            default: begin
                if (r_tmr == c_ALLRED_LAST) begin
                    w_state_nxt = IDLE;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_PHASES; i++) light[i] = COLOR_RED;
        phase_valid  = 1'b0;
        active_phase = '0;
        if (r_state == GREEN) begin
            light[r_cur] = COLOR_GREEN;
            phase_valid  = 1'b1;
            active_phase = r_cur;
        end else if (r_state == YELLOW) begin
            light[r_cur] = COLOR_YELLOW;
            phase_valid  = 1'b1;
            active_phase = r_cur;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_phase_light_controller.sv
// ============================================================================
// Module   : tb_phase_light_controller
// Brief    : Directed and randomized bench against a behavioural timing model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_light_controller;
    import light_package::*;

    localparam int N      = 5;
    localparam int GAP    = 5;
    localparam int MAXG   = 10;
    localparam int YEL    = 2;
    localparam int ALLRED = 1;

    localparam int K_IDLE   = 0;
    localparam int K_GREEN  = 1;
    localparam int K_YELLOW = 2;
    localparam int K_CLEAR  = 3;

    logic                  clk;
    logic                  reset;
    logic [N-1:0]          demand;
    colors                 light [N];
    logic [$clog2(N)-1:0]  active_phase;
    logic                  phase_valid;

    int n_checks;
    int n_errors;

    // Behavioural model: what the intersection is doing and for how long.
    int m_kind;
    int m_phase;
    int m_last;
    int m_age;
    int m_quiet;
    int m_left;

    phase_light_controller #(
        .NUM_PHASES    (N),
        .GAP_CYCLES    (GAP),
        .MAX_GREEN     (MAXG),
        .YELLOW_CYCLES (YEL),
        .ALLRED_CYCLES (ALLRED)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .demand       (demand),
        .light        (light),
        .active_phase (active_phase),
        .phase_valid  (phase_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] d);
`ifdef TLC_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (d[(m_last + k) % N]) return (m_last + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (d[k]) return k;
        end
`endif
        return 0;
    endfunction

    task automatic model_step(input logic rst_i, input logic [N-1:0] d);
        bit others;
        bit gap_out;
        bit max_out;
        if (rst_i) begin
            m_kind  = K_IDLE;
            m_phase = 0;
            m_last  = N - 1;
            return;
        end
        case (m_kind)
            K_IDLE: begin
                if (d != '0) begin
                    m_phase = pick(d);
                    m_last  = m_phase;
                    m_kind  = K_GREEN;
                    m_age   = 0;
                    m_quiet = 0;
                end
            end
            K_GREEN: begin
                others  = (d & ~(N'(1) << m_phase)) != '0;
                gap_out = !d[m_phase] && (m_quiet + 1 >= GAP);
                max_out = (m_age + 1 >= MAXG) && others;
                m_quiet = d[m_phase] ? 0 : m_quiet + 1;
                m_age++;
                if (gap_out || max_out) begin
                    m_kind = K_YELLOW;
                    m_left = YEL;
                end
            end
            K_YELLOW: begin
                m_left--;
                if (m_left == 0) begin
                    m_kind = K_CLEAR;
                    m_left = ALLRED;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_kind = K_IDLE;
            end
        endcase
    endtask

    task automatic compare_outputs();
        logic [31:0] obs_l;
        logic [31:0] exp_l;
        obs_l = '0;
        exp_l = '0;
        for (int i = 0; i < N; i++) begin
            obs_l[2*i +: 2] = light[i];
            if (i == m_phase && m_kind == K_GREEN)       exp_l[2*i +: 2] = COLOR_GREEN;
            else if (i == m_phase && m_kind == K_YELLOW) exp_l[2*i +: 2] = COLOR_YELLOW;
            else                                         exp_l[2*i +: 2] = COLOR_RED;
        end
        check("light", obs_l, exp_l);
        check("phase_valid", 32'(phase_valid), 32'(m_kind == K_GREEN || m_kind == K_YELLOW));
        check("active_phase", 32'(active_phase),
              (m_kind == K_GREEN || m_kind == K_YELLOW) ? 32'(m_phase) : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(reset, demand);
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        bit seen;
        n_checks = 0;
        n_errors = 0;
        m_kind = K_IDLE; m_phase = 0; m_last = N - 1;
        m_age = 0; m_quiet = 0; m_left = 0;
        reset  = 1'b1;
        demand = '0;
        step();
        reset = 1'b0;

        // Quiet intersection stays all-red.
        for (int i = 0; i < 50; i++) step();

        // Sole demand holds green indefinitely.
        demand = N'(1) << 2;
        step();
        check("hold_first_green", 32'(light[2]), 32'(COLOR_GREEN));
        for (int i = 0; i < 100; i++) step();
        check("hold_still_green", 32'(light[2]), 32'(COLOR_GREEN));

        // Short demand burst: G 1-8, Y 9-10, clear 11, idle 12+.
        demand = '0;
        do_reset();
        step();
        demand = N'(1) << 2;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k <= 8)       check("burst_timeline", 32'(light[2]), 32'(COLOR_GREEN));
            else if (k <= 10) check("burst_timeline", 32'(light[2]), 32'(COLOR_YELLOW));
            else              check("burst_timeline", 32'(light[2]), 32'(COLOR_RED));
            if (k == 4) demand = '0;
        end

        // Demand dips for less than the gap, then returns: no yellow.
        demand = N'(1) << 2;
        for (int i = 0; i < 6; i++) step();
        demand = '0;
        for (int i = 0; i < 4; i++) step();
        demand = N'(1) << 2;
        for (int i = 0; i < 20; i++) step();
        check("gap_restart_green", 32'(light[2]), 32'(COLOR_GREEN));

        // Contested phases 0 and 3.
        demand = '0;
        do_reset();
        demand = 5'b01001;
        for (int i = 0; i < 60; i++) step();

        // Reset during the first yellow cycle of phase 1.
        demand = '0;
        do_reset();
        demand = N'(1) << 1;
        step();
        demand = '0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (light[1] == COLOR_YELLOW) seen = 1'b1;
        end
        check("yellow_reached", 32'(seen), 32'd1);
        demand = N'(1) << 4;
        reset  = 1'b1;
        step();
        check("reset_drops_yellow", 32'(light[1]), 32'(COLOR_RED));
        reset = 1'b0;
        step();
        check("after_reset_green4", 32'(light[4]), 32'(COLOR_GREEN));

        // Randomized demand with occasional reset.
        for (int blk = 0; blk < 120; blk++) begin
            demand = N'($urandom);
            if ($urandom_range(0, 3) == 0) demand = N'(1) << $urandom_range(0, N - 1);
            reset = ($urandom_range(0, 40) == 0);
            for (int c = $urandom_range(1, 18); c > 0; c--) begin
                step();
                reset = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/phase_light_controller.md
# phase_light_controller

Parametrised N-phase traffic-light controller, the generalised successor to the fixed 5-light intersection controller. Each of NUM_PHASES phases owns one light output. The block grants green to one demanding phase at a time and times green-gap, maximum-green, yellow and all-red clearance with parameters. Round-robin arbitration among phases is selectable. It sits between the sensor-conditioning logic (demand inputs) and the lamp drivers.

## Interface
- NUM_PHASES, 5: number of phases/lights; legal 2..16
- GAP_CYCLES, 5: consecutive no-demand green cycles before yielding; ≥1
- MAX_GREEN, 10: green cycles allowed while another phase demands; ≥1
- YELLOW_CYCLES, 2: yellow duration; ≥1
- ALLRED_CYCLES, 1: all-red clearance after yellow; ≥1
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- demand  in  NUM_PHASES  per-phase traffic sensor, level-sensitive, not latched
- light  out  colors[NUM_PHASES]  per-phase lamp (red/yellow/green)
- active_phase  out  $clog2(NUM_PHASES)  phase currently green or yellow; 0 when none
- phase_valid  out  1  high in GREEN and YELLOW

## Operation
- States: IDLE (all-red hold), GREEN, YELLOW, CLEAR (all-red timed). Registers: state, cur (phase index), last (last-served phase), green_ctr, gap_ctr, tmr.
- IDLE: if any demand bit is set, select phase p, set cur=p and last=p, clear green_ctr and gap_ctr, and go to GREEN. Otherwise stay in IDLE.
- GREEN:
  - green_ctr increments and saturates at MAX_GREEN-1.
  - If demand[cur]=1, gap_ctr clears. Otherwise gap_ctr increments. Returning traffic restarts the gap.
  - Go to YELLOW if (demand[cur]=0 and gap_ctr==GAP_CYCLES-1) or (green_ctr==MAX_GREEN-1 and any demand[j], j≠cur). Both conditions true together: YELLOW, once.
  - With only demand[cur] present, green holds indefinitely.
- YELLOW: tmr counts YELLOW_CYCLES cycles, then CLEAR.
- CLEAR: tmr counts ALLRED_CYCLES cycles, then IDLE.
- Outputs are Moore outputs from registered state:
  - light[cur]=green in GREEN, yellow in YELLOW.
  - All other lights, and all lights in IDLE/CLEAR, are red.
- Counter widths: $clog2(max(param)+1). No wrap is reachable.
- Sync reset: state=IDLE, last=NUM_PHASES-1 (phase 0 top priority), cur=0, all counters 0. Reset mid-GREEN/YELLOW drops to all-red at the next edge; no yellow is inserted.

## Timing
- Demand seen in IDLE at cycle t → green at t+1.
- Contested green lasts exactly MAX_GREEN cycles.
- Uncontested green with demand removed lasts GAP_CYCLES cycles after the last demand-high cycle.
- Minimum red between two greens: ALLRED_CYCLES+1 cycles (CLEAR plus one IDLE cycle).
- Reset values: every light=red, phase_valid=0, active_phase=0.

## Configuration
- TLC_ROUND_ROBIN_EN defined: IDLE selects the first set demand bit searching (last+1) mod NUM_PHASES upward, wrapping. The same phase is regranted only when it is the sole demand.
- TLC_ROUND_ROBIN_EN undefined: fixed priority, lowest set index wins; last is unused.

## Structure
- light_package:
  - holds colors.
  - add tlc_phase_state_t enum {IDLE, GREEN, YELLOW, CLEAR}.
- Sub-module rr_phase_arbiter (parametrised NUM_PHASES):
  - combinational; inputs demand and last; outputs grant index and any_req.
  - contains the TLC_ROUND_ROBIN_EN macro switch.

## Test plan
- Reset, then demand=0 for 50 cycles → all lights red, phase_valid=0 throughout.
- Defaults, demand[2] held high from cycle 0 → light[2]=green from cycle 1 and held for 100 cycles; others red.
- demand[2] high 3 cycles, then low → green cycles 1–8 (3 demand-high + 5 gap), yellow cycles 9–10, red clear cycle 11, IDLE cycle 12.
- demand[2] high, drop for 4 cycles, restore, uncontested → no yellow; gap_ctr returns to 0 at restore.
- demand[0] and demand[3] held, with TLC_ROUND_ROBIN_EN → phase 0 green 10 cycles, yellow 2, red 2, phase 3 green 10, then phase 0. Without the macro → phase 0 regranted every time.
- Reset asserted in the 1st yellow cycle of phase 1, demand[4] only → all red at the next edge; light[4]=green 2 cycles after reset deasserts.
